// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   mdop_t    - 3-bit operation encoding carried down the pipe as mdopE
//   mdstate_t - sequencer states of mult_div_unit
//   isLegalOp - true for the six encodings the unit executes
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } mdstate_t;

    // 3'b110 and 3'b111 are no-ops and must never start anything.
    function automatic logic isLegalOp(input logic [2:0] op);
        return op <= 3'b101;
    endfunction

    // Signed variants take magnitudes at accept and fix the sign at the end.
    function automatic logic isSignedOp(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// ---------------------------------------------------------------------------
// mdu_signfix
// Combinational two's-complement conditional negate. Used both to take
// operand magnitudes at accept (negate = operand is negative) and to apply
// the result sign at completion (negate = result should be negative).
// Ports:
//   value  in  WIDTH : input word
//   negate in  1     : 1 -> result = -value, 0 -> result = value
//   result out WIDTH : conditionally negated word
// The most negative value maps onto itself, which read as unsigned is its
// correct magnitude; the divider overflow case relies on this.
// ---------------------------------------------------------------------------
module mdu_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit living in the E stage. Executes
// MULT/MULTU (WIDTH cycles), DIV/DIVU (WIDTH+1 cycles) and MTHI/MTLO
// (single cycle) and owns the HI/LO architectural registers.
// Ports:
//   clk      in  1     : clock, all state updates on rising edge
//   reset    in  1     : synchronous, active-low
//   mdstartE in  1     : a mult/div/mt instruction is in E
//   mdopE    in  3     : operation (see mdu_pkg::mdop_t)
//   srcaE    in  WIDTH : rs operand (multiplicand, dividend, MT source)
//   srcbE    in  WIDTH : rt operand (multiplier, divisor)
//   stallE   in  1     : E stage held this cycle
//   mdrunE   out 1     : operation in flight (registered)
//   hi, lo   out WIDTH : HI/LO registers (registered)
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [2:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             stallE,
    output logic             mdrunE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mdstate_t           state;
    logic [CW-1:0]      count;
    // MUL: {partial product, remaining multiplier bits}
    // DIV: {partial remainder, dividend bits / quotient bits}
    logic [2*WIDTH-1:0] work;
    logic [WIDTH-1:0]   opB;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [WIDTH-1:0]   rawA;     // dividend as captured, returned in HI on divide by zero
    logic               negRes;   // product / quotient must be negated
    logic               negRem;   // remainder must be negated (dividend sign)

    mdop_t op;
    logic  isSigned;
    logic  accept;

    assign op       = mdop_t'(mdopE);
    assign isSigned = isSignedOp(mdopE);
    // mdrunE low already implies IDLE, so this is the only gate needed.
    assign accept   = mdstartE & ~stallE & ~mdrunE & isLegalOp(mdopE);

    // ---------------------------------------------------------------
    // Operand magnitudes at accept
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    mdu_signfix #(.WIDTH(WIDTH)) uMagA (
        .value  (srcaE),
        .negate (isSigned & srcaE[WIDTH-1]),
        .result (magA)
    );

    mdu_signfix #(.WIDTH(WIDTH)) uMagB (
        .value  (srcbE),
        .negate (isSigned & srcbE[WIDTH-1]),
        .result (magB)
    );

    // ---------------------------------------------------------------
    // Multiply step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole product register right by one.
    // The carry out of the add becomes the new top bit.
    // ---------------------------------------------------------------
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;

    assign mulSum  = {1'b0, work[2*WIDTH-1:WIDTH]}
                   + {1'b0, (work[0] ? opB : {WIDTH{1'b0}})};
    assign mulNext = {mulSum, work[WIDTH-1:1]};

    // ---------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the
    // partial remainder and try subtracting the divisor. The shifted
    // remainder is WIDTH+1 bits, so the trial is done in WIDTH+2 bits
    // to keep a clean borrow in the MSB.
    // ---------------------------------------------------------------
    logic [WIDTH+1:0]   divDiff;
    logic               divFits;
    logic [2*WIDTH-1:0] divNext;

    assign divDiff = {1'b0, work[2*WIDTH-1:WIDTH-1]} - {2'b00, opB};
    assign divFits = ~divDiff[WIDTH+1];
    assign divNext = divFits ? {divDiff[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                             : {work[2*WIDTH-2:0], 1'b0};

    // ---------------------------------------------------------------
    // Result sign fix at completion
    // ---------------------------------------------------------------
    logic [2*WIDTH-1:0] prodFixed;
    logic [WIDTH-1:0]   quoFixed;
    logic [WIDTH-1:0]   remFixed;

    // The final multiply step is folded in so HI/LO land on the last
    // MUL edge rather than one cycle later.
    mdu_signfix #(.WIDTH(2*WIDTH)) uProdFix (
        .value  (mulNext),
        .negate (negRes),
        .result (prodFixed)
    );

    mdu_signfix #(.WIDTH(WIDTH)) uQuoFix (
        .value  (work[WIDTH-1:0]),
        .negate (negRes),
        .result (quoFixed)
    );

    mdu_signfix #(.WIDTH(WIDTH)) uRemFix (
        .value  (work[2*WIDTH-1:WIDTH]),
        .negate (negRem),
        .result (remFixed)
    );

    // ---------------------------------------------------------------
    // Sequencer, datapath registers and HI/LO
    // ---------------------------------------------------------------
    // NOTE: every register here is cleared by reset, including the
    // datapath ones, so an abandoned operation leaves nothing behind and
    // all state is non-blocking so the combinational step logic above
    // always sees the values from the previous edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            mdrunE <= 1'b0;
            work   <= '0;
            opB    <= '0;
            rawA   <= '0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                state  <= MUL;
                                mdrunE <= 1'b1;
                                count  <= LAST_COUNT;
                                work   <= {{WIDTH{1'b0}}, magB};
                                opB    <= magA;
                                negRes <= isSigned & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                                negRem <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                state  <= DIV;
                                mdrunE <= 1'b1;
                                count  <= LAST_COUNT;
                                work   <= {{WIDTH{1'b0}}, magA};
                                opB    <= magB;
                                rawA   <= srcaE;
                                negRes <= isSigned & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                                negRem <= isSigned & srcaE[WIDTH-1];
                            end
                            MD_MTHI: hi <= srcaE;
                            MD_MTLO: lo <= srcaE;
                            default: ;
                        endcase
                    end
                end

                MUL: begin
                    work <= mulNext;
                    if (count == '0) begin
                        {hi, lo} <= prodFixed;
                        state    <= IDLE;
                        mdrunE   <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                DIV: begin
                    work <= divNext;
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                FIX: begin
                    // A zero divisor bypasses the sign fix entirely.
                    if (opB == '0) begin
                        lo <= {WIDTH{1'b1}};
                        hi <= rawA;
                    end else begin
                        lo <= quoFixed;
                        hi <= remFixed;
                    end
                    state  <= IDLE;
                    mdrunE <= 1'b0;
                end

                default: begin
                    state  <= IDLE;
                    mdrunE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit (WIDTH = 32). Inputs are driven and
// outputs sampled on the falling clock edge. Expected {HI,LO} values come
// from a behavioural model and travel through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W       = 32;
    localparam int MUL_LEN = 32;
    localparam int DIV_LEN = 33;

    logic         clk = 1'b0;
    logic         reset;
    logic         mdstartE;
    logic [2:0]   mdopE;
    logic [W-1:0] srcaE;
    logic [W-1:0] srcbE;
    logic         stallE;
    logic         mdrunE;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0]  sbq[$];
    logic [W-1:0] hiM = '0;
    logic [W-1:0] loM = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .mdstartE (mdstartE),
        .mdopE    (mdopE),
        .srcaE    (srcaE),
        .srcbE    (srcbE),
        .stallE   (stallE),
        .mdrunE   (mdrunE),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Behavioural reference: returns {HI, LO}.
    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0]        p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (op)
            3'b000: begin p = sa * sb; return p; end
            3'b001: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'b010: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == '0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'b100: return {a, loM};
            3'b101: return {hiM, a};
            default: return {hiM, loM};
        endcase
    endfunction

    // Counts mdrunE-high cycles (starting from the cycle after accept),
    // then checks length, HI/LO stability while busy, and the result.
    task automatic wait_done(input string name, input int expLen, input bit poke);
        int          n    = 0;
        bit          held = 1'b0;
        logic [63:0] exp;
        while (mdrunE === 1'b1 && n < 200) begin
            if (hi !== hiM || lo !== loM) held = 1'b1;
            if (poke) begin
                if (n == 3) begin
                    mdstartE = 1'b1; mdopE = 3'b000;
                    srcaE = 32'h0000_1234; srcbE = 32'h0000_0005;
                end else if (n == 6) begin
                    mdstartE = 1'b0;
                end
            end
            n++;
            @(negedge clk);
        end
        compared++;
        if (n !== expLen) begin
            mismatched++;
            $display("FAIL %s_busy_len: got %0d cycles, expected %0d", name, n, expLen);
        end
        compared++;
        if (held) begin
            mismatched++;
            $display("FAIL %s_hilo_stable: HI/LO changed while busy", name);
        end
        compared++;
        if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL %s_scoreboard: no expected entry", name);
        end else begin
            exp = sbq.pop_front();
            if ({hi, lo} !== exp) begin
                mismatched++;
                $display("FAIL %s_result: hi=%h lo=%h, expected hi=%h lo=%h",
                         name, hi, lo, exp[63:32], exp[31:0]);
            end
            hiM = exp[63:32];
            loM = exp[31:0];
        end
    endtask

    // Issue a multi-cycle op on the current falling edge; returns on the
    // first falling edge with mdrunE low.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        sbq.push_back(model(op, a, b));
        mdstartE = 1'b1; mdopE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        mdstartE = 1'b0;
        wait_done(name, (op[1] ? DIV_LEN : MUL_LEN), poke);
    endtask

    task automatic test_reset();
        reset = 1'b0; mdstartE = 1'b0; mdopE = '0; srcaE = '0; srcbE = '0; stallE = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (mdrunE !== 1'b0 || hi !== '0 || lo !== '0) begin
            mismatched++;
            $display("FAIL reset_state: mdrunE=%b hi=%h lo=%h, expected 0/0/0", mdrunE, hi, lo);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op("mult_neg", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op("multu",    3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op("mult_mix", 3'b000, 32'h8000_0000, 32'h8000_0000, 1'b0);
    endtask

    task automatic test_div();
        run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("divu",      3'b011, 32'h0000_0007, 32'h0000_0002, 1'b0);
        run_op("div_negb",  3'b010, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);
        run_op("divu_zero", 3'b011, 32'h0000_0007, 32'h0000_0000, 1'b0);
        run_op("div_zero",  3'b010, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0);
        run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            run_op("random", op, $urandom, (i == 5) ? 32'h0000_0003 : $urandom, 1'b0);
        end
    endtask

    task automatic test_stall();
        sbq.push_back(model(3'b000, 32'h0000_0003, 32'hFFFF_FFFB));
        mdstartE = 1'b1; mdopE = 3'b000; srcaE = 32'h0000_0003; srcbE = 32'hFFFF_FFFB;
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (mdrunE !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_hold: mdrunE=%b in stall cycle %0d, expected 0", mdrunE, i);
            end
        end
        stallE = 1'b0;
        @(negedge clk);
        mdstartE = 1'b0;
        compared++;
        if (mdrunE !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_accept: mdrunE=%b after unstall, expected 1", mdrunE);
        end
        wait_done("stall", MUL_LEN, 1'b0);
        repeat (3) @(negedge clk);
        compared++;
        if (mdrunE !== 1'b0 || sbq.size() != 0) begin
            mismatched++;
            $display("FAIL stall_once: mdrunE=%b pending=%0d, expected 0/0", mdrunE, sbq.size());
        end
    endtask

    task automatic test_mt();
        logic [63:0] exp;
        mdstartE = 1'b1; mdopE = 3'b101; srcaE = 32'h1234_5678;
        sbq.push_back(model(3'b101, srcaE, '0));
        @(negedge clk);
        exp = sbq.pop_front();
        compared++;
        if ({hi, lo} !== exp || mdrunE !== 1'b0) begin
            mismatched++;
            $display("FAIL mtlo: hi=%h lo=%h run=%b, expected hi=%h lo=%h run=0",
                     hi, lo, mdrunE, exp[63:32], exp[31:0]);
        end
        hiM = exp[63:32]; loM = exp[31:0];
        mdopE = 3'b100; srcaE = 32'hCAFE_F00D;
        sbq.push_back(model(3'b100, srcaE, '0));
        @(negedge clk);
        mdstartE = 1'b0;
        exp = sbq.pop_front();
        compared++;
        if ({hi, lo} !== exp || mdrunE !== 1'b0) begin
            mismatched++;
            $display("FAIL mthi: hi=%h lo=%h run=%b, expected hi=%h lo=%h run=0",
                     hi, lo, mdrunE, exp[63:32], exp[31:0]);
        end
        hiM = exp[63:32]; loM = exp[31:0];
        // Reserved encoding must do nothing.
        mdstartE = 1'b1; mdopE = 3'b110; srcaE = 32'hDEAD_BEEF;
        @(negedge clk);
        mdstartE = 1'b0;
        @(negedge clk);
        compared++;
        if (hi !== hiM || lo !== loM || mdrunE !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal_op: hi=%h lo=%h run=%b, expected hi=%h lo=%h run=0",
                     hi, lo, mdrunE, hiM, loM);
        end
    endtask

    task automatic test_ignore();
        run_op("ignore", 3'b001, 32'h0001_0000, 32'h0001_0001, 1'b1);
        @(negedge clk);
        compared++;
        if (mdrunE !== 1'b0) begin
            mismatched++;
            $display("FAIL ignore_no_restart: mdrunE=%b, expected 0", mdrunE);
        end
    endtask

    task automatic test_back_to_back();
        // Each run_op returns on the first idle cycle and issues immediately.
        run_op("b2b_1", 3'b011, 32'h0000_0064, 32'h0000_0007, 1'b0);
        run_op("b2b_2", 3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
        run_op("b2b_3", 3'b010, 32'h8000_0001, 32'h0000_0010, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp;
        sbq.push_back(model(3'b010, 32'h7FFF_FFFF, 32'h0000_0013));
        mdstartE = 1'b1; mdopE = 3'b010; srcaE = 32'h7FFF_FFFF; srcbE = 32'h0000_0013;
        @(negedge clk);
        mdstartE = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (mdrunE !== 1'b0 || hi !== '0 || lo !== '0 || dut.state !== IDLE) begin
            mismatched++;
            $display("FAIL reset_mid: run=%b hi=%h lo=%h state=%0d, expected 0/0/0/IDLE",
                     mdrunE, hi, lo, dut.state);
        end
        sbq.delete();
        hiM = '0; loM = '0;
        reset = 1'b1;
        exp = model(3'b000, 32'hFFFF_FFF0, 32'h0000_0100);
        sbq.push_back(exp);
        mdstartE = 1'b1; mdopE = 3'b000; srcaE = 32'hFFFF_FFF0; srcbE = 32'h0000_0100;
        @(negedge clk);
        mdstartE = 1'b0;
        compared++;
        if (mdrunE !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release_accept: mdrunE=%b, expected 1", mdrunE);
        end
        wait_done("post_reset", MUL_LEN, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt();
        test_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
